dtw_ref_reader: RTL and testbench
=================================

Name: dtw_ref_reader

Overview:
- Read-side counterpart of the reference loader.
- Sweeps reference-memory addresses 0..ref_len-1, captures the 1-cycle-latency read data, and writes each sample in address order into a destination FIFO. The FIFO feeds the DTW datapath or host readback.
- Owns the memory address bus during a sweep.
- Absorbs FIFO backpressure with a 2-entry skid buffer, so no sample is lost or duplicated.

Parameters:
- DATA_WIDTH, 16, sample width.
- ADDR_WIDTH, 32, width of the length and config words.
- REFMEM_PTR_WIDTH, 20, reference-memory address width.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- start_in  input  1  one-cycle start request.
- abort_in  input  1  synchronous abort.
- ref_load_done_in  input  1  reference memory holds valid data.
- ref_len_in  input  ADDR_WIDTH  samples to stream; low REFMEM_PTR_WIDTH bits are used.
- busy_out  output  1  sweep in progress.
- done_out  output  1  one-cycle pulse when the sweep completes.
- ref_addr_out  output  REFMEM_PTR_WIDTH  memory read address.
- ref_data_in  input  DATA_WIDTH  memory read data, valid one cycle after the address.
- dst_fifo_wren_out  output  1  FIFO write enable.
- dst_fifo_data_out  output  DATA_WIDTH  FIFO write data.
- dst_fifo_full_in  input  1  FIFO full.
- dst_fifo_clear_out  output  1  FIFO clear.
- checksum_out  output  32  running sample sum (see Optional Feature).
- dbg_state  output  2  FSM state.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; skid buffer empty; in-flight flag 0.
- States: IDLE=0, STREAM=1, DRAIN=2.
- IDLE:
  - start_in & ref_load_done_in & len!=0 → STREAM. The address counter is 0, and len is latched into a register; later ref_len_in changes are ignored.
  - start_in & ref_load_done_in & len==0 → done_out pulses the next cycle; stay IDLE.
  - start_in & !ref_load_done_in → ignored.
- Read issue (STREAM):
  - A read is issued in cycle t when (buffer count + in-flight) < 2.
  - Issuing means ref_addr_out = counter, then counter increments and in-flight is set for t+1.
  - Data is captured into the buffer at t+1.
  - When the issued address equals len-1 → DRAIN.
- DRAIN: no new issues. When the buffer is empty and in-flight=0 → IDLE, with done_out pulsing for exactly one cycle on that transition.
- Emit:
  - When the buffer is non-empty and !dst_fifo_full_in, drive dst_fifo_wren_out=1 with the head sample and pop.
  - Push and pop in the same cycle is legal; the count is unchanged.
  - FIFO-write latency: when unthrottled, sample k is written 2 cycles after its address is issued.
- Throughput: one sample per cycle when the FIFO never fills; the sweep takes len+2 cycles from the STREAM entry to done_out.
- Full: no write while full. The buffer holds at most 2 entries, the issue rule guarantees no overflow, and the order is strictly preserved.
- busy_out = 1 in STREAM and DRAIN.
- dst_fifo_clear_out pulses for one cycle on start acceptance and on abort.
- abort_in (any state) → IDLE on the next edge:
  - buffer flushed and in-flight dropped;
  - no done_out and no further writes.
  - abort_in has priority over start_in in the same cycle.
- start_in while busy: ignored.
- ref_addr_out holds its last value when not issuing.
- Asynchronous reset mid-sweep: everything returns to reset values immediately.

Optional Feature:
- Macro: DTW_REF_READER_CHECKSUM_EN.
- Defined:
  - checksum_out = modulo-2^32 sum of every sample written to the FIFO, zero-extended.
  - Cleared on start acceptance.
  - Holds after done_out until the next start.
- Undefined: checksum_out tied to 0 and no accumulator is built.

Decomposition:
- Shared package dtw_pkg holds:
  - FSM state encodings IDLE/STREAM/DRAIN;
  - MODE_DTW_READ/MODE_LOAD_REF;
  - version field ranges.
- One sub-module: dtw_skid_buf2, the 2-entry FIFO with push/pop/count and full/empty.

Test Plan:
- len=8, FIFO never full, memory = address+0x100 → 8 writes 0x100..0x107 on consecutive cycles; done_out pulses one cycle, 10 cycles after the start is accepted.
- len=16, dst_fifo_full_in asserted for cycles 3–9 → all 16 samples written in order with no duplicates; ref_addr_out never exceeds 15.
- len=0 with ref_load_done_in=1 → no writes, no busy; done_out pulses once.
- start_in with ref_load_done_in=0 → stays IDLE, no clear pulse, no writes.
- len=32, abort_in at the 10th write → IDLE next cycle; clear pulses; no more writes; no done_out. A subsequent start streams 32 samples from address 0.
- CHECKSUM_EN: len=4, samples 0xFFFF ×4 → checksum_out = 0x0003FFFC; the macro undefined gives 0.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW reference-memory blocks.
package dtw_pkg;

  // Reference reader FSM encoding (also exported on dbg_state)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } dtw_state_e;

  // Reference memory ownership mode
  typedef enum logic {
    MODE_DTW_READ = 1'b0,
    MODE_LOAD_REF = 1'b1
  } dtw_mode_e;

  // Version word field ranges
  localparam int unsigned VER_MAJOR_MSB = 31;
  localparam int unsigned VER_MAJOR_LSB = 24;
  localparam int unsigned VER_MINOR_MSB = 23;
  localparam int unsigned VER_MINOR_LSB = 16;
  localparam int unsigned VER_PATCH_MSB = 15;
  localparam int unsigned VER_PATCH_LSB = 0;

endpackage

// File: rtl/dtw_ref_reader_if.sv
// Memory read bus plus destination FIFO write bus of the reference reader.
interface dtw_ref_reader_if #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned REFMEM_PTR_WIDTH = 20
);
  logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out;
  logic [DATA_WIDTH-1:0]       ref_data_in;
  logic                        dst_fifo_wren_out;
  logic [DATA_WIDTH-1:0]       dst_fifo_data_out;
  logic                        dst_fifo_full_in;
  logic                        dst_fifo_clear_out;

  // Reader side
  modport master (
    output ref_addr_out, dst_fifo_wren_out, dst_fifo_data_out, dst_fifo_clear_out,
    input  ref_data_in, dst_fifo_full_in
  );

  // Memory / FIFO side
  modport slave (
    input  ref_addr_out, dst_fifo_wren_out, dst_fifo_data_out, dst_fifo_clear_out,
    output ref_data_in, dst_fifo_full_in
  );
endinterface

// File: rtl/dtw_skid_buf2.sv
// Two-entry in-order skid buffer; caller guarantees no push into a full buffer without a pop.
module dtw_skid_buf2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         flush_in,
  input  logic         push_in,
  input  logic [W-1:0] push_data_in,
  input  logic         pop_in,
  output logic [W-1:0] head_out,
  output logic [1:0]   count_out,
  output logic         full_out,
  output logic         empty_out
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  // Pointer, count and storage update
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_in) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_in) begin
        mem_d[wr_q] = push_data_in;
        wr_d        = ~wr_q;
      end
      if (pop_in && !empty_out) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + 2'(push_in) - 2'(pop_in && !empty_out);
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_out  = mem_q[rd_q];
  assign count_out = count_q;
  assign full_out  = (count_q == 2'd2);
  assign empty_out = (count_q == 2'd0);
endmodule

// File: rtl/dtw_ref_reader.sv
// Sweeps reference memory 0..len-1 and streams samples in order into the destination FIFO.
// Optional running checksum of written samples: define DTW_REF_READER_CHECKSUM_EN.
module dtw_ref_reader
  import dtw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned REFMEM_PTR_WIDTH = 20
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  ref_load_done_in,
  input  logic [ADDR_WIDTH-1:0] ref_len_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [31:0]           checksum_out,
  output logic [1:0]            dbg_state,
  dtw_ref_reader_if.master      bus
);
  localparam int unsigned PW = REFMEM_PTR_WIDTH;

  dtw_state_e    state_q, state_d;
  logic [PW-1:0] len_q, len_d, cnt_q, cnt_d, addr_q, addr_d;
  logic          inflight_q, inflight_d, done_q, done_d, clear_q, clear_d;

  logic [DATA_WIDTH-1:0] skid_head;
  logic [1:0]            skid_count;
  logic                  skid_full, skid_empty;
  logic                  pop_c, push_c, issue_c, accept_c, flush_c;
  logic [2:0]            occ_c, fill_next_c;
  logic [PW-1:0]         len_lo_c;
  logic                  unused_len_hi;

  assign len_lo_c      = ref_len_in[PW-1:0];
  assign unused_len_hi = ^ref_len_in[ADDR_WIDTH-1:PW];

  // Issue/emit decisions and FSM next state
  always_comb begin
    pop_c       = !skid_empty && !bus.dst_fifo_full_in;
    push_c      = inflight_q && (!skid_full || pop_c);
    // Occupancy after this cycle's pop, counting the read already in flight
    occ_c       = 3'(skid_count) + 3'(inflight_q) - 3'(pop_c);
    fill_next_c = 3'(skid_count) + 3'(push_c) - 3'(pop_c);
    issue_c     = (state_q == ST_STREAM) && !abort_in && (occ_c < 3'd2);
    accept_c    = (state_q == ST_IDLE) && start_in && ref_load_done_in && !abort_in;
    flush_c     = 1'b0;
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    inflight_d  = issue_c;
    done_d      = 1'b0;
    clear_d     = 1'b0;
    if (issue_c) begin
      addr_d = cnt_q;
      cnt_d  = cnt_q + PW'(1);
    end
    if (abort_in) begin
      state_d    = ST_IDLE;
      inflight_d = 1'b0;
      flush_c    = 1'b1;
      clear_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            clear_d = 1'b1;
            if (len_lo_c != '0) begin
              state_d = ST_STREAM;
              len_d   = len_lo_c;
              cnt_d   = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (issue_c && (cnt_q == len_q - PW'(1))) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((fill_next_c == 3'd0) && !inflight_d) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      clear_q    <= clear_d;
    end
  end

  // Captured read data waiting for FIFO space
  dtw_skid_buf2 #(.W(DATA_WIDTH)) u_skid (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .flush_in     (flush_c),
    .push_in      (push_c && !flush_c),
    .push_data_in (bus.ref_data_in),
    .pop_in       (pop_c),
    .head_out     (skid_head),
    .count_out    (skid_count),
    .full_out     (skid_full),
    .empty_out    (skid_empty)
  );

`ifdef DTW_REF_READER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  // Running sum of samples handed to the FIFO
  always_comb begin
    sum_d = sum_q;
    if (accept_c)   sum_d = '0;
    else if (pop_c) sum_d = sum_q + 32'(skid_head);
  end

  // Checksum register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) sum_q <= '0;
    else           sum_q <= sum_d;
  end

  assign checksum_out = sum_q;
`else
  assign checksum_out = '0;
`endif

  assign bus.ref_addr_out       = issue_c ? cnt_q : addr_q;
  assign bus.dst_fifo_wren_out  = pop_c;
  assign bus.dst_fifo_data_out  = skid_head;
  assign bus.dst_fifo_clear_out = clear_q;
  assign busy_out               = (state_q != ST_IDLE);
  assign done_out               = done_q;
  assign dbg_state              = state_q;
endmodule

// File: tb/tb_dtw_ref_reader.sv
// Randomized self-checking bench for dtw_ref_reader against an in-order stream model.
module tb_dtw_ref_reader;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned PW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          ref_load_done_in = 1'b0;
  logic [AW-1:0] ref_len_in = '0;
  logic          busy_out, done_out;
  logic [31:0]   checksum_out;
  logic [1:0]    dbg_state;

  dtw_ref_reader_if #(.DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(PW)) bus ();

  dtw_ref_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start_in),
    .abort_in         (abort_in),
    .ref_load_done_in (ref_load_done_in),
    .ref_len_in       (ref_len_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .checksum_out     (checksum_out),
    .dbg_state        (dbg_state),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Reference memory with one cycle read latency
  logic [15:0] mem [64];
  always @(posedge clk) bus.ref_data_in <= mem[bus.ref_addr_out[5:0]];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One sweep: model expects mem[0..n-1] in order, done once, clear once (twice with abort)
  task automatic run_sweep(input int len, input int full_mode, input int abort_at, input int fill_mode);
    int n_wr, n_done, n_clr, done_k, abort_k, max_addr, ew;
    logic [31:0] exp_sum;
    bit finished;
    for (int i = 0; i < 64; i++) begin
      case (fill_mode)
        0:       mem[i] = 16'(i + 'h100);
        1:       mem[i] = 16'hFFFF;
        default: mem[i] = 16'($urandom);
      endcase
    end
    n_wr = 0; n_done = 0; n_clr = 0; done_k = -1; max_addr = 0;
    abort_k = (abort_at >= 0) ? abort_at + 1 : -1;
    @(posedge clk); #1;
    start_in = 1'b1; ref_load_done_in = 1'b1;
    ref_len_in = {12'($urandom), 20'(len)};
    bus.dst_fifo_full_in = 1'b0;
    @(posedge clk); #1;
    finished = 0;
    for (int k = 0; k < 6 * len + 40 && !finished; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start_in   = (abort_at < 0 && k < len) ? ($urandom_range(0, 3) == 0) : 1'b0;
      ref_len_in = $urandom;
      abort_in   = (k == abort_k);
      case (full_mode)
        1:       bus.dst_fifo_full_in = (k >= 3 && k <= 9);
        2:       bus.dst_fifo_full_in = ($urandom_range(0, 2) == 0);
        default: bus.dst_fifo_full_in = 1'b0;
      endcase
      @(negedge clk);
      if (k == 0) begin
        chk("busy_k0", 32'(busy_out), 32'(len != 0));
        chk("state_k0", 32'(dbg_state), (len != 0) ? 32'd1 : 32'd0);
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
      end
      if (bus.dst_fifo_clear_out) n_clr++;
      if (len > 0 && int'(bus.ref_addr_out) > max_addr) max_addr = int'(bus.ref_addr_out);
      if (bus.dst_fifo_wren_out) begin
        chk("wr_full", 32'(bus.dst_fifo_full_in), 32'd0);
        if (n_wr < len) begin
          chk("wr_data", 32'(bus.dst_fifo_data_out), 32'(mem[n_wr]));
          if (full_mode == 0) chk("wr_lat", 32'(k), 32'(2 + n_wr));
        end else begin
          chk("wr_extra", 32'(n_wr + 1), 32'(len));
        end
        n_wr++;
      end
      if (done_out) begin
        n_done++;
        if (n_done == 1) begin
          done_k = k;
          if (full_mode == 0 && abort_at < 0) chk("done_lat", 32'(k), (len == 0) ? 32'd0 : 32'(len + 2));
        end
      end
      if (done_k >= 0 && k >= done_k + 4) finished = 1;
      if (abort_k >= 0 && k >= abort_k + 10) finished = 1;
    end
    start_in = 1'b0; abort_in = 1'b0; bus.dst_fifo_full_in = 1'b0;
    ew = (abort_at >= 0) ? abort_at : len;
    chk("n_wr", 32'(n_wr), 32'(ew));
    chk("n_done", 32'(n_done), (abort_at >= 0) ? 32'd0 : 32'd1);
    chk("busy_end", 32'(busy_out), 32'd0);
    if (len > 0) begin
      chk("n_clr", 32'(n_clr), (abort_at >= 0) ? 32'd2 : 32'd1);
      if (abort_at < 0) chk("addr_max", 32'(max_addr), 32'(len - 1));
      exp_sum = '0;
      for (int i = 0; i < ew; i++) exp_sum += 32'(mem[i]);
`ifdef DTW_REF_READER_CHECKSUM_EN
      chk("csum", checksum_out, exp_sum);
`else
      chk("csum", checksum_out, 32'd0);
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen, clr_seen, wr_seen, done_seen;
    bus.dst_fifo_full_in = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #23;
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_wren", 32'(bus.dst_fifo_wren_out), 32'd0);
    chk("rst_clear", 32'(bus.dst_fifo_clear_out), 32'd0);
    chk("rst_addr", 32'(bus.ref_addr_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_csum", checksum_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_sweep(8, 0, -1, 0);
    run_sweep(16, 1, -1, 2);
    run_sweep(0, 0, -1, 2);

    // start without valid reference data is ignored
    @(posedge clk); #1;
    start_in = 1'b1; ref_load_done_in = 1'b0; ref_len_in = 32'd5;
    @(posedge clk); #1; start_in = 1'b0;
    busy_seen = 0; clr_seen = 0; wr_seen = 0; done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      busy_seen += int'(busy_out);
      clr_seen  += int'(bus.dst_fifo_clear_out);
      wr_seen   += int'(bus.dst_fifo_wren_out);
      done_seen += int'(done_out);
    end
    chk("nr_busy", 32'(busy_seen), 32'd0);
    chk("nr_clear", 32'(clr_seen), 32'd0);
    chk("nr_wr", 32'(wr_seen), 32'd0);
    chk("nr_done", 32'(done_seen), 32'd0);
    ref_load_done_in = 1'b1;

    run_sweep(32, 0, 10, 2);
    run_sweep(32, 2, -1, 2);
    run_sweep(4, 0, -1, 1);
    for (int r = 0; r < 4; r++) run_sweep($urandom_range(1, 40), ($urandom_range(0, 1) == 0) ? 0 : 2, -1, 2);

    // asynchronous reset in the middle of a sweep
    @(posedge clk); #1;
    start_in = 1'b1; ref_len_in = 32'd32;
    @(posedge clk); #1; start_in = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    chk("arst_wren", 32'(bus.dst_fifo_wren_out), 32'd0);
    chk("arst_addr", 32'(bus.ref_addr_out), 32'd0);
    chk("arst_csum", checksum_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_sweep(5, 0, -1, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
